// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Byte-wide UART transmitter for the keyboard serial link. A rising edge on the
// level-style send enable requests one 8N1 frame. The frame is a start bit,
// then eight data bits LSB first, then one stop bit. Each bit is held for
// CLK_FREQ / UART_BPS clocks.
//
// Ports:
//   clock     in   1  system clock, all state updates on the rising edge
//   reset     in   1  asynchronous, active-low reset
//   uart_en   in   1  send enable (level); a 0->1 transition requests a frame
//   uart_din  in   8  byte to send, captured when the request is accepted
//   uart_txd  out  1  serial line, idles high
//   tx_busy   out  1  high while a frame is on the line
//   tx_done   out  1  one-cycle pulse after the stop bit completes
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_en,
    input  logic [7:0] uart_din,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    // Clocks per bit; the configuration must give at least 2.
    localparam int               BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam int               CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BPS_CNT - 1);
    localparam logic [3:0]       LAST_BIT = 4'd8;   // index of data bit 7
    localparam logic [3:0]       STOP_BIT = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             e0;
    logic             e1;
    logic             start;
    logic [CNT_W-1:0] clk_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       tx_data;
    logic             bit_end;
    logic             frame_end;

    // A request is the first cycle in which the synchronised enable is high.
    assign start     = e0 & ~e1;
    assign bit_end   = (clk_cnt == CNT_MAX);
    assign frame_end = bit_end && (bit_cnt == STOP_BIT);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Requests seen while in SEND are ignored, including the
    // one that lands on the SEND->IDLE edge.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = SEND;
            SEND:    if (frame_end) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        tx_busy = (state == SEND);
    end

    // -------------------------------------------------------------------------
    // Datapath: edge detector, bit timing, captured byte and the registered
    // serial line. The line is registered so it never glitches.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            e0       <= 1'b0;
            e1       <= 1'b0;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            tx_data  <= '0;
            uart_txd <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            e0      <= uart_en;
            e1      <= e0;
            tx_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        tx_data  <= uart_din;
                        clk_cnt  <= '0;
                        bit_cnt  <= '0;
                        uart_txd <= 1'b0;              // start bit
                    end
                end
                SEND: begin
                    if (!bit_end) begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end else begin
                        clk_cnt <= '0;
                        if (bit_cnt == STOP_BIT) begin
                            // Stop bit finished: the line stays high.
                            bit_cnt  <= '0;
                            uart_txd <= 1'b1;
                            tx_done  <= 1'b1;
                        end else begin
                            // The new bit index is bit_cnt+1, so the data bit
                            // to send is tx_data[bit_cnt]. After bit 7 comes
                            // the stop bit.
                            bit_cnt  <= bit_cnt + 4'd1;
                            uart_txd <= (bit_cnt == LAST_BIT) ? 1'b1
                                                              : tx_data[bit_cnt[2:0]];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx with BPS_CNT = 16. A per-cycle reference
// model predicts the line, busy and done from the frame rules. The model tracks
// request edges, frame start times and the bit index as time/16. A table of
// hand-written frames and a few directed sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CLK_FREQ = 160;
    localparam int UART_BPS = 10;
    localparam int BPS      = 16;
    localparam int FRAME    = 10 * BPS;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       uart_en  = 1'b0;
    logic [7:0] uart_din = 8'h00;
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;
    bit sb_on  = 1'b0;

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .uart_en  (uart_en),
        .uart_din (uart_din),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model. It counts rising edges. A request seen at edge n starts
    // a frame at edge n+1 if no frame is still running at that edge. A frame
    // that starts at edge s runs through edge s+FRAME-1. Its done pulse is at
    // edge s+FRAME.
    // -------------------------------------------------------------------------
    logic exp_txd  = 1'b1;
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;

    initial begin : model
        int         cyc;
        bit         prev_en;
        bit         pending;
        bit         have;
        int         s;
        int         fend;
        logic [9:0] frame;
        logic [9:0] shifted;
        cyc = 0; prev_en = 0; pending = 0; have = 0; s = 0; fend = 0;
        frame = '1;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                pending  = 0;
                have     = 0;
                prev_en  = 0;
                exp_txd  = 1'b1;
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end else begin
                cyc++;
                if (pending && (!have || cyc > fend)) begin
                    have  = 1;
                    s     = cyc;
                    fend  = cyc + FRAME;
                    frame = {1'b1, uart_din, 1'b0};
                end
                pending = 0;
                if (have && cyc >= s && cyc < fend) begin
                    shifted  = frame >> ((cyc - s) / BPS);
                    exp_busy = 1'b1;
                    exp_txd  = shifted[0];
                end else begin
                    exp_busy = 1'b0;
                    exp_txd  = 1'b1;
                end
                exp_done = have && (cyc == fend);
                pending  = uart_en && !prev_en;
                prev_en  = uart_en;
            end
        end
    end

    // Scoreboard: compare every cycle, away from the rising edge.
    always @(negedge clock) begin
        if (sb_on) begin
            check("sb_txd",  uart_txd, exp_txd);
            check("sb_busy", tx_busy,  exp_busy);
            check("sb_done", tx_done,  exp_done);
        end
    end

    // Raise the enable, or use one already raised, then wait for the start bit.
    // Then follow the frame: sample each bit mid-way and count the busy and
    // done cycles. The enable drops at k=20. An optional re-raise happens at
    // raise_k with raise_din.
    task automatic run_frame(input logic [7:0] din, input bit skip_raise, input bit scramble,
                             input int raise_k, input logic [7:0] raise_din, input bit stop_on_done,
                             output logic [9:0] line, output int busy_n, output int done_n,
                             output int done_k, output int lat);
        bit found;
        line = '1; busy_n = 0; done_n = 0; done_k = -1; lat = 0; found = 0;
        if (!skip_raise) begin
            @(negedge clock);
            uart_din = din;
            uart_en  = 1'b1;
        end
        for (int t = 0; t < 8; t++) begin
            @(negedge clock);
            lat++;
            if (uart_txd === 1'b0) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            lat = -1;
            uart_en = 1'b0;
            return;
        end
        for (int k = 0; k < 170; k++) begin
            if (k > 0) @(negedge clock);
            if (k == 0 && scramble) uart_din = 8'h00;
            if (k < FRAME && (k % BPS) == BPS / 2) line = {uart_txd, line[9:1]};
            if (tx_busy === 1'b1) busy_n++;
            if (tx_done === 1'b1) begin
                done_n++;
                done_k = k;
                if (stop_on_done) return;
            end
            if (k == 20) uart_en = 1'b0;
            if (k == raise_k) begin
                uart_en  = 1'b1;
                uart_din = raise_din;
            end
        end
    endtask

    typedef struct {
        logic [7:0] din;
        bit         scramble;
        logic [9:0] line;      // bit i = i-th bit on the wire (start first)
    } vec_t;

    initial begin : main
        vec_t       vecs[6];
        logic [9:0] line;
        int         busy_n, done_n, done_k, lat;
        int         act;
        int         seen;

        vecs[0] = '{8'h55, 1'b0, 10'b1010101010};
        vecs[1] = '{8'hA3, 1'b1, 10'b1101000110};   // data changed after capture
        vecs[2] = '{8'h0F, 1'b0, 10'b1000011110};
        vecs[3] = '{8'h81, 1'b0, 10'b1100000010};
        vecs[4] = '{8'h00, 1'b0, 10'b1000000000};
        vecs[5] = '{8'hFF, 1'b1, 10'b1111111110};

        // 1. Reset values, then a quiet line after release.
        repeat (3) @(negedge clock);
        check("rst_txd",  uart_txd, 1);
        check("rst_busy", tx_busy,  0);
        check("rst_done", tx_done,  0);
        sb_on = 1'b1;
        reset = 1'b1;
        act = 0;
        repeat (500) begin
            @(negedge clock);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) act++;
        end
        check("idle_500", act, 0);

        // 2/3. Table of frames, including data changed right after capture.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].din, 0, vecs[i].scramble, -1, 8'h00, 0,
                      line, busy_n, done_n, done_k, lat);
            check($sformatf("vec%0d_latency", i), lat,    2);
            check($sformatf("vec%0d_line", i),    line,   vecs[i].line);
            check($sformatf("vec%0d_busy", i),    busy_n, FRAME);
            check($sformatf("vec%0d_done_n", i),  done_n, 1);
            check($sformatf("vec%0d_done_k", i),  done_k, FRAME);
        end

        // 4. Retrigger while busy: the second request is dropped.
        run_frame(8'h0F, 0, 0, 50, 8'hFF, 0, line, busy_n, done_n, done_k, lat);
        check("retrig_line",   line,   10'b1000011110);
        check("retrig_done_n", done_n, 1);
        check("retrig_busy",   busy_n, FRAME);
        act = 0;
        repeat (200) begin
            @(negedge clock);
            if (uart_txd === 1'b0 || tx_busy === 1'b1 || tx_done === 1'b1) act++;
        end
        check("retrig_no_second", act, 0);
        uart_en = 1'b0;
        repeat (5) @(negedge clock);

        // 5. Back-to-back: re-raise in the tx_done cycle.
        run_frame(8'h3C, 0, 0, -1, 8'h00, 1, line, busy_n, done_n, done_k, lat);
        check("b2b_first_line",   line,   10'b1001111000);
        check("b2b_first_done_k", done_k, FRAME);
        uart_din = 8'h81;
        uart_en  = 1'b1;
        run_frame(8'h81, 1, 0, -1, 8'h00, 0, line, busy_n, done_n, done_k, lat);
        check("b2b_latency", lat,    2);
        check("b2b_line",    line,   10'b1100000010);
        check("b2b_done_n",  done_n, 1);

        // 6. Reset in the middle of a data bit.
        @(negedge clock);
        uart_din = 8'hC6;
        uart_en  = 1'b1;
        act = 0;
        while (uart_txd !== 1'b0 && act < 8) begin
            @(negedge clock);
            act++;
        end
        check("midrst_started", uart_txd, 0);
        repeat (70) @(negedge clock);
        uart_en = 1'b0;
        check("midrst_busy_before", tx_busy, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_txd",  uart_txd, 1);
        check("midrst_busy", tx_busy,  0);
        check("midrst_done", tx_done,  0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        act = 0;
        repeat (300) begin
            @(negedge clock);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) act++;
        end
        check("midrst_idle_after", act, 0);

        // Random enable/data traffic with one asynchronous reset pulse,
        // checked cycle by cycle against the model.
        seen = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            if (tx_done === 1'b1) seen++;
            uart_din = 8'($urandom);
            if ($urandom_range(0, 29) == 0) uart_en = ~uart_en;
            if (c == 2500) #2 reset = 1'b0;
            if (c == 2504) reset = 1'b1;
        end
        check("rand_frames_seen", (seen >= 5) ? 1 : 0, 1);

        uart_en = 1'b0;
        repeat (200) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
